seg_scan_driver: RTL



---
 rtl/seg_scan_driver.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - multiplexed seven-segment driver with double-buffered valid/ready updates
// Optional leading-zero suppression is built when SEG_SCAN_LZ_BLANK_EN is defined.
module seg_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int TICK_DIV     = 100000,
    parameter int BLANK_CYCLES = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [4*NUM_DIGITS-1:0]   upd_data,
    input  logic [NUM_DIGITS-1:0]     upd_dp,
    input  logic                      upd_valid,
    output logic                      upd_ready,
    output logic [6:0]                seg_n,
    output logic                      dp_n,
    output logic [NUM_DIGITS-1:0]     an_n,
    output logic                      frame_done
);

    localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    // A zero blanking request still costs the one index-advance cycle.
    localparam int BLANK_LEN = (BLANK_CYCLES < 1) ? 1 : BLANK_CYCLES;
    localparam int CNT_MAX   = (TICK_DIV > BLANK_LEN) ? TICK_DIV : BLANK_LEN;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic {
        ST_BLANK,
        ST_SHOW
    } state_t;

    state_t                         state;
    logic [CNT_W-1:0]               cnt;
    logic [IDX_W-1:0]               idx;
    logic [NUM_DIGITS-1:0][3:0]     disp_data;
    logic [NUM_DIGITS-1:0]          disp_dp;
    logic [NUM_DIGITS-1:0][3:0]     pend_data;
    logic [NUM_DIGITS-1:0]          pend_dp;
    logic [6:0]                     cur_seg;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

`ifdef SEG_SCAN_LZ_BLANK_EN
    logic [NUM_DIGITS-1:0] lz_mask;

    // A digit is suppressed while it and every digit to its left are zero.
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        lz_mask  = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run   = zero_run && (disp_data[i] == 4'h0);
            lz_mask[i] = zero_run && (i != 0);
        end
    end
`endif

    always_comb begin
        cur_seg = seg_decode(disp_data[idx]);
`ifdef SEG_SCAN_LZ_BLANK_EN
        if (lz_mask[idx]) begin
            cur_seg = 7'h7F;
        end
`endif
    end

    // Outputs are registered from the current state, so they trail the FSM by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_BLANK;
            cnt        <= '0;
            idx        <= '0;
            disp_data  <= '0;
            disp_dp    <= '0;
            pend_data  <= '0;
            pend_dp    <= '0;
            upd_ready  <= 1'b1;
            seg_n      <= 7'h7F;
            dp_n       <= 1'b1;
            an_n       <= '1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            if (upd_valid && upd_ready) begin
                pend_data <= upd_data;
                pend_dp   <= upd_dp;
                upd_ready <= 1'b0;
            end

            case (state)
                ST_BLANK: begin
                    an_n  <= '1;
                    seg_n <= 7'h7F;
                    dp_n  <= 1'b1;
                    if (cnt == BLANK_LAST) begin
                        cnt   <= '0;
                        state <= ST_SHOW;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_SHOW: begin
                    an_n  <= ~(NUM_DIGITS'(1) << idx);
                    seg_n <= cur_seg;
                    dp_n  <= ~disp_dp[idx];
                    if (cnt == SHOW_LAST) begin
                        cnt   <= '0;
                        state <= ST_BLANK;
                        if (idx == IDX_LAST) begin
                            idx        <= '0;
                            frame_done <= 1'b1;
                            // Commit only at the wrap so a frame never mixes old and new digits.
                            if (!upd_ready) begin
                                disp_data <= pend_data;
                                disp_dp   <= pend_dp;
                                upd_ready <= 1'b1;
                            end
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_BLANK;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
